// File: rtl/ps2mouse_init.sv
// ---------------------------------------------------------------------------
// ps2mouse_init
//
// PS/2 mouse initialisation sequencer. It runs a fixed command script through
// the byte-level PS/2 host transceiver: reset (FF), the IntelliMouse wheel
// probe (sample-rate writes 200/100/80 followed by Get ID), and finally
// Enable Data Reporting (F4). Every device response is checked. On a bad or
// missing response the whole script restarts, up to MAX_RETRY attempts. The
// block then reports whether the mouse is streaming and whether it has a wheel.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   restart    : one-cycle pulse; aborts everything and restarts from step 0
//   tx_data    : command byte for the transceiver, stable while tx_req is high
//   tx_req     : send request, held until tx_done or tx_err
//   tx_done    : one-cycle pulse, byte fully sent
//   tx_err     : one-cycle pulse, transceiver send failure
//   rx_data    : received byte
//   rx_valid   : one-cycle pulse qualifying rx_data
//   init_ready : script complete, mouse is streaming
//   wheel      : device reported ID 0x03
//   init_error : retries exhausted; sticky until reset or restart
// ---------------------------------------------------------------------------
module ps2mouse_init #(
  parameter int ACK_TIMEOUT = 140000,
  parameter int BAT_TIMEOUT = 3500000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_done,
  input  logic       tx_err,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       init_ready,
  output logic       wheel,
  output logic       init_error
);

  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [21:0] ACK_LOAD = 22'(ACK_TIMEOUT);
  localparam logic [21:0] BAT_LOAD = 22'(BAT_TIMEOUT);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID_STD = 8'h00;
  localparam logic [7:0] RSP_ID_WHL = 8'h03;

  typedef enum logic [2:0] {
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_WAIT_ID0,
    ST_WAIT_ID,
    ST_DONE,
    ST_FAIL
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [3:0]      r_step;
  logic [3:0]      w_nextStep;
  logic [RW-1:0]   r_retry;
  logic [RW-1:0]   w_nextRetry;
  logic [RW-1:0]   w_retryInc;
  logic [21:0]     r_timer;
  logic [21:0]     w_nextTimer;
  logic            r_wheel;
  logic            w_nextWheel;
  logic            w_fail;
  logic            w_resend;
  logic            r_txReq;
  logic [7:0]      r_txData;
  logic            r_initReady;
  logic            r_initError;

  // Command script: reset, sample rate 200/100/80 (the wheel unlock knock),
  // Get Device ID, Enable Data Reporting.
  function automatic logic [7:0] romByte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'hFF;
      4'd1:    b = 8'hF3;
      4'd2:    b = 8'hC8;
      4'd3:    b = 8'hF3;
      4'd4:    b = 8'h64;
      4'd5:    b = 8'hF3;
      4'd6:    b = 8'h50;
      4'd7:    b = 8'hF2;
      4'd8:    b = 8'hF4;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign w_retryInc = r_retry + RW'(1);

  // Next-state logic. Responses are examined before timer expiry so a byte
  // arriving on the expiry cycle still counts. Failure and resend handling
  // share the retry bookkeeping at the bottom, and restart overrides all.
  always_comb begin
    w_nextState = r_state;
    w_nextStep  = r_step;
    w_nextRetry = r_retry;
    w_nextTimer = (r_timer != 22'd0) ? (r_timer - 22'd1) : r_timer;
    w_nextWheel = r_wheel;
    w_fail      = 1'b0;
    w_resend    = 1'b0;

    case (r_state)
      ST_SEND: begin
        if (r_txReq) begin
          if (tx_err) begin
            w_fail = 1'b1;
          end else if (tx_done) begin
            w_nextState = ST_WAIT_ACK;
            w_nextTimer = ACK_LOAD;
          end
        end
      end

      ST_WAIT_ACK: begin
        if (rx_valid) begin
          if (rx_data == RSP_ACK) begin
            if (r_step == 4'd0) begin
              w_nextState = ST_WAIT_BAT;
              w_nextTimer = BAT_LOAD;
            end else if (r_step == 4'd7) begin
              w_nextState = ST_WAIT_ID;
              w_nextTimer = ACK_LOAD;
            end else if (r_step == 4'd8) begin
              w_nextState = ST_DONE;
              w_nextRetry = '0;
            end else begin
              w_nextState = ST_SEND;
              w_nextStep  = r_step + 4'd1;
            end
          end else if (rx_data == RSP_RESEND) begin
            w_resend = 1'b1;
          end else begin
            w_fail = 1'b1;
          end
        end else if (r_timer == 22'd0) begin
          w_fail = 1'b1;
        end
      end

      ST_WAIT_BAT: begin
        if (rx_valid) begin
          if (rx_data == RSP_BAT_OK) begin
            w_nextState = ST_WAIT_ID0;
            w_nextTimer = ACK_LOAD;
          end else begin
            w_fail = 1'b1;
          end
        end else if (r_timer == 22'd0) begin
          w_fail = 1'b1;
        end
      end

      ST_WAIT_ID0: begin
        if (rx_valid) begin
          if (rx_data == RSP_ID_STD) begin
            w_nextState = ST_SEND;
            w_nextStep  = 4'd1;
          end else begin
            w_fail = 1'b1;
          end
        end else if (r_timer == 22'd0) begin
          w_fail = 1'b1;
        end
      end

      ST_WAIT_ID: begin
        if (rx_valid) begin
          w_nextWheel = (rx_data == RSP_ID_WHL);
          w_nextState = ST_SEND;
          w_nextStep  = 4'd8;
        end else if (r_timer == 22'd0) begin
          w_fail = 1'b1;
        end
      end

      ST_DONE: begin
        w_nextState = ST_DONE;
      end

      ST_FAIL: begin
        w_nextState = ST_FAIL;
      end

      default: begin
        w_nextState = ST_SEND;
        w_nextStep  = 4'd0;
      end
    endcase

    // A resend request repeats the current step; a failure rewinds the whole
    // script. Both consume one retry and give up once the budget is spent.
    if (w_fail || w_resend) begin
      w_nextRetry = w_retryInc;
      if (w_retryInc == RETRY_MAX) begin
        w_nextState = ST_FAIL;
      end else begin
        w_nextState = ST_SEND;
        if (w_fail) begin
          w_nextStep  = 4'd0;
          w_nextWheel = 1'b0;
        end
      end
    end

    if (restart) begin
      w_nextState = ST_SEND;
      w_nextStep  = 4'd0;
      w_nextRetry = '0;
      w_nextWheel = 1'b0;
      w_nextTimer = r_timer;
    end
  end

  // State register. Outputs are registered from the next state so that
  // tx_req drops on the very edge that samples tx_done/tx_err and the
  // status flags change on the edge that samples the deciding byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SEND;
      r_step      <= 4'd0;
      r_retry     <= '0;
      r_timer     <= 22'd0;
      r_wheel     <= 1'b0;
      r_txReq     <= 1'b0;
      r_txData    <= 8'h00;
      r_initReady <= 1'b0;
      r_initError <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_step      <= w_nextStep;
      r_retry     <= w_nextRetry;
      r_timer     <= w_nextTimer;
      r_wheel     <= w_nextWheel;
      r_txReq     <= (w_nextState == ST_SEND);
      r_txData    <= (w_nextState == ST_SEND) ? romByte(w_nextStep) : 8'h00;
      r_initReady <= (w_nextState == ST_DONE);
      r_initError <= (w_nextState == ST_FAIL);
    end
  end

  assign tx_req     = r_txReq;
  assign tx_data    = r_txData;
  assign init_ready = r_initReady;
  assign wheel      = r_wheel;
  assign init_error = r_initError;

endmodule
